// File: rtl/host_mem_pkg.sv
// host_mem_pkg: shared widths, cache-line geometry and controller state encoding.
package host_mem_pkg;

  localparam int ADDR_WIDTH       = 64;
  localparam int CL_WIDTH         = 512;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int WD_WIDTH         = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_GO,
    RD_WAIT,
    WR_GO,
    WR_WAIT,
    WR_DONE,
    RESP
  } state_t;

endpackage

// File: rtl/host_mem_ctrl.sv
// host_mem_ctrl: bridges single miner cache-line requests onto the host DMA
// read/write handshake, one request outstanding, with a wait-state watchdog.
module host_mem_ctrl #(
  parameter int ADDR_WIDTH = host_mem_pkg::ADDR_WIDTH,
  parameter int CL_WIDTH   = host_mem_pkg::CL_WIDTH,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [CL_WIDTH-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [CL_WIDTH-1:0]   rsp_rdata,
  input  logic [ADDR_WIDTH-1:0] address_offset,
  output logic [ADDR_WIDTH-1:0] corrected_address,
  output logic                  host_rgo,
  output logic                  host_wgo,
  input  logic                  host_rd_ready,
  input  logic                  host_wr_ready,
  output logic                  host_re,
  output logic                  host_we,
  input  logic [CL_WIDTH-1:0]   host_data_bus_read_in,
  output logic [CL_WIDTH-1:0]   host_data_bus_write_out,
  input  logic                  host_wr_done
);

  import host_mem_pkg::*;

  // Clears the byte-within-line bits so the DMA always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_OFFSET_BITS) - ADDR_WIDTH'(1));

  state_t                state;
  state_t                next_state;
  logic [WD_WIDTH-1:0]   wd_cnt;
  logic                  wd_expired;
  logic                  err_q;
  logic                  set_err;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_sum;

  assign addr_sum   = req_addr + address_offset;
  assign wd_expired = (32'(wd_cnt) + 32'd1) >= 32'(TIMEOUT);
  assign accept     = req_valid && req_ready;

  // Next-state and handshake outputs; re/we are gated directly by the ready inputs.
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    req_ready  = 1'b0;
    host_rgo   = 1'b0;
    host_wgo   = 1'b0;
    host_re    = 1'b0;
    host_we    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          next_state = req_we ? WR_GO : RD_GO;
        end
      end
      RD_GO: begin
        host_rgo   = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (host_rd_ready) begin
          host_re    = 1'b1;
          next_state = RESP;
        end else if (wd_expired) begin
          set_err    = 1'b1;
          next_state = RESP;
        end
      end
      WR_GO: begin
        host_wgo   = 1'b1;
        next_state = WR_WAIT;
      end
      WR_WAIT: begin
        if (host_wr_ready) begin
          host_we    = 1'b1;
          next_state = WR_DONE;
        end else if (wd_expired) begin
          set_err    = 1'b1;
          next_state = RESP;
        end
      end
      WR_DONE: begin
        if (host_wr_done) begin
          next_state = RESP;
        end else if (wd_expired) begin
          set_err    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, watchdog (restarts on every state change) and error flag for RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wd_cnt <= '0;
      end else if (state == RD_WAIT || state == WR_WAIT || state == WR_DONE) begin
        wd_cnt <= wd_cnt + WD_WIDTH'(1);
      end
      if (next_state == RESP) begin
        err_q <= set_err;
      end
    end
  end

  // Request address/data are frozen at accept so offset changes cannot disturb a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corrected_address       <= '0;
      host_data_bus_write_out <= '0;
      rsp_rdata               <= '0;
    end else begin
      if (accept) begin
        corrected_address       <= addr_sum & LINE_MASK;
        host_data_bus_write_out <= req_wdata;
      end
      if (host_re) begin
        rsp_rdata <= host_data_bus_read_in;
      end
    end
  end

endmodule

// File: tb/tb_host_mem_ctrl.sv
// tb_host_mem_ctrl: randomized transactions scored against a transaction-level
// schedule model (expected pulse cycles, error, data) plus directed corner cases.
module tb_host_mem_ctrl;

  localparam int AW = 64;
  localparam int CW = 512;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [CW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [CW-1:0] rsp_rdata;
  logic [AW-1:0] address_offset = '0;
  logic [AW-1:0] corrected_address;
  logic          host_rgo;
  logic          host_wgo;
  logic          host_rd_ready = 1'b0;
  logic          host_wr_ready = 1'b0;
  logic          host_re;
  logic          host_we;
  logic [CW-1:0] host_data_bus_read_in = '0;
  logic [CW-1:0] host_data_bus_write_out;
  logic          host_wr_done = 1'b0;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] last_rdata = '0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  host_mem_ctrl #(.ADDR_WIDTH(AW), .CL_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .address_offset(address_offset), .corrected_address(corrected_address),
    .host_rgo(host_rgo), .host_wgo(host_wgo),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .host_re(host_re), .host_we(host_we),
    .host_data_bus_read_in(host_data_bus_read_in),
    .host_data_bus_write_out(host_data_bus_write_out),
    .host_wr_done(host_wr_done)
  );

  task automatic checkOutput(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] randLine();
    logic [CW-1:0] v;
    for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete request. d1 = cycles the DMA ready stays low in the first wait
  // state; d2 = cycles wr_done stays low after the write beat.
  task automatic applyStimulus(input string name, input logic we, input logic [AW-1:0] addr,
                               input logic [AW-1:0] off, input int d1, input int d2);
    logic [CW-1:0] wdata;
    logic [CW-1:0] rbus;
    logic [AW-1:0] exp_addr;
    int            exp_io;
    int            exp_rsp;
    logic          exp_err;
    int            go_cnt = 0;
    int            go_cyc = -1;
    int            io_cnt = 0;
    int            io_cyc = -1;
    int            rsp_cyc = -1;
    int            other_go = 0;
    int            viol = 0;
    logic          got_err = 1'b0;
    logic [CW-1:0] got_rdata = '0;

    wdata    = randLine();
    rbus     = randLine();
    exp_addr = (addr + off) & ~64'h3F;
    if (d1 >= TO) begin
      exp_io = -1; exp_rsp = 2 + TO; exp_err = 1'b1;
    end else if (!we) begin
      exp_io = 2 + d1; exp_rsp = 3 + d1; exp_err = 1'b0;
    end else if (d2 >= TO) begin
      exp_io = 2 + d1; exp_rsp = 3 + d1 + TO; exp_err = 1'b1;
    end else begin
      exp_io = 2 + d1; exp_rsp = 4 + d1 + d2; exp_err = 1'b0;
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    address_offset        = off;
    host_data_bus_read_in = rbus;
    #1;
    checkOutput({name, ":req_ready"}, CW'(req_ready), CW'(1));
    @(posedge clk);
    #1;
    req_valid      = 1'b0;
    req_addr       = {$urandom, $urandom};
    req_wdata      = randLine();
    address_offset = {$urandom, $urandom};

    for (int c = 1; c <= 80 && rsp_cyc < 0; c++) begin
      host_rd_ready = !we && (c >= 2 + d1);
      host_wr_ready = we && (c >= 2 + d1);
      host_wr_done  = we && (c >= 3 + d1 + d2);
      @(negedge clk);
      if (host_rgo || host_wgo) begin
        if (host_wgo === we && host_rgo === !we) begin
          go_cnt++;
          if (go_cyc < 0) go_cyc = c;
        end else begin
          other_go++;
        end
      end
      if (host_re || host_we) begin
        io_cnt++;
        if (io_cyc < 0) io_cyc = c;
        if ((host_re && !host_rd_ready) || (host_we && !host_wr_ready) ||
            (host_re && we) || (host_we && !we)) viol++;
      end
      if (corrected_address !== exp_addr || host_data_bus_write_out !== wdata) viol++;
      if (rsp_valid) begin
        rsp_cyc   = c;
        got_err   = rsp_err;
        got_rdata = rsp_rdata;
      end
      if (rsp_cyc < 0) begin
        @(posedge clk);
        #1;
      end
    end

    if (!we && !exp_err) last_rdata = rbus;
    checkOutput({name, ":go_count"}, CW'(go_cnt), CW'(1));
    checkOutput({name, ":go_cycle"}, CW'(go_cyc), CW'(1));
    checkOutput({name, ":wrong_go"}, CW'(other_go), CW'(0));
    checkOutput({name, ":io_cycle"}, CW'(io_cyc), CW'(exp_io));
    checkOutput({name, ":io_count"}, CW'(io_cnt), CW'((exp_io < 0) ? 0 : 1));
    checkOutput({name, ":rsp_cycle"}, CW'(rsp_cyc), CW'(exp_rsp));
    checkOutput({name, ":rsp_err"}, CW'(got_err), CW'(exp_err));
    checkOutput({name, ":rsp_rdata"}, got_rdata, last_rdata);
    checkOutput({name, ":hold_violations"}, CW'(viol), CW'(0));

    @(posedge clk);
    #1;
    host_rd_ready = 1'b0;
    host_wr_ready = 1'b0;
    host_wr_done  = 1'b0;
    @(negedge clk);
    checkOutput({name, ":back_to_idle"}, CW'({rsp_valid, req_ready}), CW'(2'b01));
  endtask

  // Reset checks, directed corner cases, then a randomized transaction mix.
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset:controls",
                CW'({req_ready, rsp_valid, rsp_err, host_rgo, host_wgo, host_re, host_we}), CW'(0));
    checkOutput("reset:corrected_address", CW'(corrected_address), CW'(0));
    checkOutput("reset:write_out", host_data_bus_write_out, '0);
    checkOutput("reset:rsp_rdata", rsp_rdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset:ready_after", CW'(req_ready), CW'(1));

    applyStimulus("read_basic", 1'b0, 64'h40, 64'h1000, 0, 0);
    applyStimulus("write_stall", 1'b1, 64'h7F, 64'h0, 5, 2);
    applyStimulus("wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h80, 1, 0);
    applyStimulus("rd_timeout", 1'b0, 64'h1234, 64'h0, 20, 0);
    applyStimulus("rd_last_ok", 1'b0, 64'h2000, 64'h55, TO - 1, 0);
    applyStimulus("wr_timeout", 1'b1, 64'h3000, 64'h0, TO, 0);
    applyStimulus("wr_done_timeout", 1'b1, 64'h4000, 64'h0, 0, TO);
    applyStimulus("wr_fast", 1'b1, 64'h5001, 64'h3F, 0, 0);

    // Reset while parked in WR_WAIT must abort silently.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h9000;
    req_wdata = randLine();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset:pulses",
                CW'({req_ready, rsp_valid, host_rgo, host_wgo, host_re, host_we}), CW'(0));
    checkOutput("mid_reset:corrected_address", CW'(corrected_address), CW'(0));
    last_rdata = '0;
    rst_n = 1'b1;
    #1;
    checkOutput("mid_reset:ready_after", CW'(req_ready), CW'(1));
    applyStimulus("after_reset_read", 1'b0, 64'h80, 64'h40, 0, 0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($sformatf("rand%0d", n), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
